// File: rtl/video_pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_pll_reset_ctrl
// Brief    : Video PLL reset sequencer and lock supervisor. Define
//            VIDEO_PLL_LOSS_CNT_EN to build the lock-loss event counter.
// Revision : 1.0 - initial release
// ============================================================================
module video_pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] c_ZERO        = '0;
  localparam logic [TW-1:0] c_ONE         = TW'(1);
  localparam logic [TW-1:0] c_RST_END     = TW'(PLL_RST_CYCLES);
  localparam logic [TW-1:0] c_TIMEOUT_END = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] c_STABLE_END  = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    c_MAX_RETRY   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_nxt;
  logic [3:0]    w_retry_inc;
  logic          r_lk_meta;
  logic          r_lk_sync;
  logic          r_pll_rst;
  logic          r_video_rst;
  logic          r_ready;
  logic          r_fault;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lk_meta <= 1'b0;
      r_lk_sync <= 1'b0;
    end else begin
      r_lk_meta <= pll_locked;
      r_lk_sync <= r_lk_meta;
    end
  end

  assign w_retry_inc = r_retry + 4'd1;

  // Internal re-entries into RESET_PLL load the timer with 1 because the
  // entry edge already starts the first pll_rst cycle; reset and soft_req
  // start from 0, giving one extra hold cycle as the sequence leaves reset.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry;
    if (soft_req) begin
      w_state_nxt = S_RESET_PLL;
      w_timer_nxt = c_ZERO;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_timer == c_RST_END) begin
            w_state_nxt = S_WAIT_LOCK;
            w_timer_nxt = c_ZERO;
          end else begin
            w_timer_nxt = r_timer + c_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_sync) begin
            w_state_nxt = S_STABILIZE;
            w_timer_nxt = c_ZERO;
          end else if (r_timer == c_TIMEOUT_END) begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == c_MAX_RETRY) begin
              w_state_nxt = S_FAULT;
              w_timer_nxt = c_ZERO;
            end else begin
              w_state_nxt = S_RESET_PLL;
              w_timer_nxt = c_ONE;
            end
          end else begin
            w_timer_nxt = r_timer + c_ONE;
          end
        end
        S_STABILIZE: begin
          if (!r_lk_sync) begin
            w_state_nxt = S_WAIT_LOCK;
            w_timer_nxt = c_ZERO;
          end else if (r_timer == c_STABLE_END) begin
            w_state_nxt = S_RUN;
            w_timer_nxt = c_ZERO;
            w_retry_nxt = 4'd0;
          end else begin
            w_timer_nxt = r_timer + c_ONE;
          end
        end
        S_RUN: begin
          if (!r_lk_sync) begin
            w_state_nxt = S_RESET_PLL;
            w_timer_nxt = c_ONE;
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_timer_nxt = c_ZERO;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_RESET_PLL;
      r_timer     <= c_ZERO;
      r_retry     <= 4'd0;
      r_pll_rst   <= 1'b1;
      r_video_rst <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL);
      r_video_rst <= (w_state_nxt != S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
    end
  end

`ifdef VIDEO_PLL_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;
  logic       w_loss_evt;

  // Counted even when soft_req overrides the resulting transition.
  assign w_loss_evt = (r_state == S_RUN) && !r_lk_sync;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst   = r_pll_rst;
  assign video_rst = r_video_rst;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_video_pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pll_reset_ctrl
// Brief    : Scoreboard bench for video_pll_reset_ctrl (edge-indexed expects).
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_pll_reset_ctrl;

  localparam int P_RST  = 4;
  localparam int P_TO   = 100;
  localparam int P_STB  = 8;
  localparam int P_MAXR = 3;

`ifdef VIDEO_PLL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam int S_PLL_RST = 0;
  localparam int S_VRST    = 1;
  localparam int S_READY   = 2;
  localparam int S_FAULT   = 3;
  localparam int S_RETRY   = 4;
  localparam int S_LOSS    = 5;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       pll_rst;
  logic       video_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  video_pll_reset_ctrl #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STB),
    .MAX_RETRIES   (P_MAXR)
  ) u_dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_req     (soft_req),
    .pll_rst      (pll_rst),
    .video_rst    (video_rst),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  // Edge 0 is the first rising edge that samples rst low.
  int edge_no = -1;
  always @(posedge refclk) edge_no <= rst ? -1 : edge_no + 1;

  typedef struct {
    int    e;
    int    sig;
    int    val;
    string tag;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic int obs_of(input int sig);
    case (sig)
      S_PLL_RST: return int'(pll_rst);
      S_VRST:    return int'(video_rst);
      S_READY:   return int'(ready);
      S_FAULT:   return int'(fault);
      S_RETRY:   return int'(retry_cnt);
      default:   return int'(lock_loss_cnt);
    endcase
  endfunction

  function automatic int loss_exp(input int n);
    int sat;
    sat = (n > 255) ? 255 : n;
    return LOSS_EN ? sat : 0;
  endfunction

  task automatic exp_at(input int e, input int sig, input int val, input string tag);
    sb_item_t it;
    it.e   = e;
    it.sig = sig;
    it.val = val;
    it.tag = tag;
    sb.push_back(it);
  endtask

  always @(negedge refclk) begin : monitor
    sb_item_t it;
    while (sb.size() > 0 && sb[0].e <= edge_no) begin
      it = sb.pop_front();
      if (it.e == edge_no) check_eq(it.tag, obs_of(it.sig), it.val);
      else check_eq({it.tag, "_late"}, edge_no, it.e);
    end
  end

  task automatic at_edge(input int e);
    int guard;
    guard = 0;
    if (edge_no > e) check_eq("stim_late", edge_no, e);
    while (edge_no < e && guard < 20000) begin
      @(posedge refclk);
      #1;
      guard++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 20000) begin
      @(posedge refclk);
      #1;
      guard++;
    end
    if (sb.size() > 0) begin
      check_eq("sb_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    soft_req = 1'b0;
    repeat (2) begin
      @(posedge refclk);
      #1;
    end
    exp_at(-1, S_PLL_RST, 1, "rst_pll_rst");
    exp_at(-1, S_VRST,    1, "rst_video_rst");
    exp_at(-1, S_READY,   0, "rst_ready");
    exp_at(-1, S_FAULT,   0, "rst_fault");
    exp_at(-1, S_RETRY,   0, "rst_retry");
    exp_at(-1, S_LOSS,    0, "rst_loss");
    @(posedge refclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #(20 * 50000);
    $display("FAIL watchdog: edge %0d, expected finish", edge_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Bring-up: lock appears after edge 20.
    do_reset();
    exp_at(3,  S_PLL_RST, 1, "bu_prst_hold");
    exp_at(4,  S_PLL_RST, 0, "bu_prst_fall");
    exp_at(30, S_READY,   0, "bu_ready_early");
    exp_at(30, S_VRST,    1, "bu_vrst_early");
    exp_at(31, S_READY,   1, "bu_ready_rise");
    exp_at(31, S_VRST,    0, "bu_vrst_fall");
    exp_at(31, S_RETRY,   0, "bu_retry");
    at_edge(20);
    pll_locked = 1'b1;
    drain();

    // No lock: three timeouts then fault.
    do_reset();
    exp_at(3,   S_PLL_RST, 1, "nl_p1_hold");
    exp_at(4,   S_PLL_RST, 0, "nl_p1_fall");
    exp_at(103, S_PLL_RST, 0, "nl_p2_pre");
    exp_at(104, S_PLL_RST, 1, "nl_p2_rise");
    exp_at(104, S_RETRY,   1, "nl_retry1");
    exp_at(107, S_PLL_RST, 1, "nl_p2_hold");
    exp_at(108, S_PLL_RST, 0, "nl_p2_fall");
    exp_at(208, S_PLL_RST, 1, "nl_p3_rise");
    exp_at(208, S_RETRY,   2, "nl_retry2");
    exp_at(211, S_PLL_RST, 1, "nl_p3_hold");
    exp_at(212, S_PLL_RST, 0, "nl_p3_fall");
    exp_at(311, S_FAULT,   0, "nl_fault_early");
    exp_at(312, S_FAULT,   1, "nl_fault_rise");
    exp_at(312, S_RETRY,   3, "nl_retry3");
    exp_at(312, S_PLL_RST, 0, "nl_fault_prst");
    exp_at(350, S_FAULT,   1, "nl_fault_held");
    exp_at(350, S_PLL_RST, 0, "nl_fault_prst_held");
    exp_at(350, S_VRST,    1, "nl_fault_vrst");
    drain();

    // Recovery from fault with soft_req.
    exp_at(360, S_FAULT,   1, "rc_fault_pre");
    exp_at(361, S_FAULT,   0, "rc_fault_clr");
    exp_at(361, S_PLL_RST, 1, "rc_prst");
    exp_at(361, S_RETRY,   0, "rc_retry");
    exp_at(362, S_PLL_RST, 1, "rc_prst_hold");
    at_edge(360);
    soft_req = 1'b1;
    at_edge(361);
    soft_req = 1'b0;
    drain();

    // Glitch during STABILIZE restarts the stability count.
    do_reset();
    exp_at(28, S_RETRY, 0, "gl_retry_mid");
    exp_at(31, S_READY, 0, "gl_no_early_ready");
    exp_at(36, S_READY, 0, "gl_ready_pre");
    exp_at(37, S_READY, 1, "gl_ready_rise");
    exp_at(37, S_RETRY, 0, "gl_retry");
    at_edge(20);
    pll_locked = 1'b1;
    at_edge(25);
    pll_locked = 1'b0;
    at_edge(26);
    pll_locked = 1'b1;
    drain();

    // Lock loss in RUN, then re-lock.
    exp_at(52, S_VRST,    0, "ll_vrst_pre");
    exp_at(52, S_READY,   1, "ll_ready_pre");
    exp_at(53, S_VRST,    1, "ll_vrst_rise");
    exp_at(53, S_READY,   0, "ll_ready_fall");
    exp_at(53, S_PLL_RST, 1, "ll_prst_rise");
    exp_at(53, S_LOSS,    loss_exp(1), "ll_loss1");
    exp_at(56, S_PLL_RST, 1, "ll_prst_hold");
    exp_at(57, S_PLL_RST, 0, "ll_prst_fall");
    exp_at(71, S_READY,   1, "ll_relock");
    exp_at(71, S_LOSS,    loss_exp(1), "ll_loss_kept");
    at_edge(50);
    pll_locked = 1'b0;
    at_edge(60);
    pll_locked = 1'b1;
    drain();

    // Repeated losses up to and past saturation.
    for (int n = 2; n <= 260; n++) begin
      int d;
      d = 80 + (n - 2) * 25;
      if (n <= 3 || n >= 254) exp_at(d + 3, S_LOSS, loss_exp(n), $sformatf("sat_loss_%0d", n));
      if (n == 260) exp_at(d + 21, S_READY, 1, "sat_final_run");
      at_edge(d);
      pll_locked = 1'b0;
      at_edge(d + 10);
      pll_locked = 1'b1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
